// File: rtl/hazard_pkg.sv
// Shared types and defaults for the scoreboarded pipeline hazard unit.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  // Forwarding mux select for the E-stage operands.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10,
    FWD_MC = 2'b11
  } fwd_e;

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Pipeline <-> hazard unit bundle: stage register info in, stall/flush/forward controls out.
interface hazard_unit_sb_if #(
  parameter int REG_ADDR_W  = hazard_pkg::REG_ADDR_W_DEF,
  parameter int NUM_REGS    = 2 ** REG_ADDR_W,
  parameter int STALL_CNT_W = 16
);

  logic [REG_ADDR_W-1:0]  rs1_d, rs2_d, rd_d;
  logic                   uses_rs1_d, uses_rs2_d, reg_write_d, mc_op_d;
  logic [REG_ADDR_W-1:0]  rs1_e, rs2_e, rd_e;
  logic                   result_src_load_e, pc_src_e, mc_issue_e;
  logic [REG_ADDR_W-1:0]  rd_m, rd_w;
  logic                   reg_write_m, reg_write_w;
  logic                   mc_done, mc_busy;
  logic [REG_ADDR_W-1:0]  mc_rd;
  logic                   stall_f, stall_d, flush_d, flush_e;
  logic [1:0]             forward_ae, forward_be;
  logic [NUM_REGS-1:0]    sb_pending;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // The pipeline side drives stage info and consumes controls.
  modport master (
    output rs1_d, rs2_d, rd_d, uses_rs1_d, uses_rs2_d, reg_write_d, mc_op_d,
    output rs1_e, rs2_e, rd_e, result_src_load_e, pc_src_e, mc_issue_e,
    output rd_m, rd_w, reg_write_m, reg_write_w, mc_done, mc_rd, mc_busy,
    input  stall_f, stall_d, flush_d, flush_e, forward_ae, forward_be,
    input  sb_pending, stall_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rd_d, uses_rs1_d, uses_rs2_d, reg_write_d, mc_op_d,
    input  rs1_e, rs2_e, rd_e, result_src_load_e, pc_src_e, mc_issue_e,
    input  rd_m, rd_w, reg_write_m, reg_write_w, mc_done, mc_rd, mc_busy,
    output stall_f, stall_d, flush_d, flush_e, forward_ae, forward_be,
    output sb_pending, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-write bit per register for the multi-cycle unit, with three
// write-first lookup ports (a completing result is not pending to readers).
module hazard_scoreboard #(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W_DEF,
  parameter int NUM_REGS   = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr0,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic [2:0]            pend,
  output logic [NUM_REGS-1:0]   pending
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Clear is applied first so a same-cycle set on the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) pending_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  always_comb begin
    pend[0] = pending_q[rd_addr0] & ~(clr_en & (clr_addr == rd_addr0));
    pend[1] = pending_q[rd_addr1] & ~(clr_en & (clr_addr == rd_addr1));
    pend[2] = pending_q[rd_addr2] & ~(clr_en & (clr_addr == rd_addr2));
  end

  assign pending = pending_q;

endmodule

// File: rtl/hazard_unit_sb.sv
// 5-stage hazard unit: load-use and multi-cycle scoreboard stalls, branch
// flush with priority over stalls, four-source forwarding, stall counter.
module hazard_unit_sb #(
  parameter int REG_ADDR_W  = hazard_pkg::REG_ADDR_W_DEF,
  parameter int NUM_REGS    = 2 ** REG_ADDR_W,
  parameter int STALL_CNT_W = 16
) (
  input logic             clk,
  input logic             reset,
  hazard_unit_sb_if.slave hz
);
  import hazard_pkg::*;

  logic [2:0]             pend;
  logic                   load_use, mc_raw, mc_waw, mc_struct, hz_any, stall;
  logic [STALL_CNT_W-1:0] cnt_q;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_REGS   (NUM_REGS)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (hz.mc_issue_e),
    .set_addr (hz.rd_e),
    .clr_en   (hz.mc_done),
    .clr_addr (hz.mc_rd),
    .rd_addr0 (hz.rs1_d),
    .rd_addr1 (hz.rs2_d),
    .rd_addr2 (hz.rd_d),
    .pend     (pend),
    .pending  (hz.sb_pending)
  );

  function automatic logic match_nz(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (match_nz(rs, hz.rd_m) && hz.reg_write_m)    return FWD_M;
    else if (match_nz(rs, hz.rd_w) && hz.reg_write_w) return FWD_W;
    else if (match_nz(rs, hz.mc_rd) && hz.mc_done)  return FWD_MC;
    else                                            return FWD_RF;
  endfunction

  // Issue-cycle hazards come from the rd_e compare; later cycles from the scoreboard.
  always_comb begin
    load_use  = hz.result_src_load_e &
                ((hz.uses_rs1_d & match_nz(hz.rs1_d, hz.rd_e)) |
                 (hz.uses_rs2_d & match_nz(hz.rs2_d, hz.rd_e)));
    mc_raw    = (hz.uses_rs1_d & (hz.rs1_d != '0) &
                 (pend[0] | (hz.mc_issue_e & (hz.rs1_d == hz.rd_e)))) |
                (hz.uses_rs2_d & (hz.rs2_d != '0) &
                 (pend[1] | (hz.mc_issue_e & (hz.rs2_d == hz.rd_e))));
    mc_waw    = hz.reg_write_d & (hz.rd_d != '0) &
                (pend[2] | (hz.mc_issue_e & (hz.rd_d == hz.rd_e)));
    mc_struct = hz.mc_op_d & hz.mc_busy & ~hz.mc_done;
    hz_any    = load_use | mc_raw | mc_waw | mc_struct;
    stall     = hz_any & ~hz.pc_src_e & ~reset;
  end

  always_comb begin
    hz.stall_f    = stall;
    hz.stall_d    = stall;
    hz.flush_d    = hz.pc_src_e;
    hz.flush_e    = hz.pc_src_e | hz_any;
    hz.forward_ae = fwd_sel(hz.rs1_e);
    hz.forward_be = fwd_sel(hz.rs2_e);
    if (reset) begin
      hz.flush_d    = 1'b1;
      hz.flush_e    = 1'b1;
      hz.forward_ae = FWD_RF;
      hz.forward_be = FWD_RF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                       cnt_q <= '0;
    else if (stall && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign hz.stall_cnt = cnt_q;

endmodule
